// File: rtl/sdram_frame_sched.sv
// sdram_frame_sched
//    Schedules SDRAM burst requests for a triple-buffered video frame store.
//    Write bursts drain the write FIFO into the write buffer; read bursts
//    refill the read FIFO from the read buffer. A completed write frame is
//    handed to the reader through ready_bank. If no newer frame has arrived,
//    the reader repeats the one it already has.
//
// Ports
//    sysclk_100M     sole clock
//    rst             asynchronous reset, active-high
//    w_fifo_count    write-FIFO read-side level
//    r_fifo_count    read-FIFO write-side level
//    wr_frame_start  pulse: restart the write frame at address 0
//    wr_req/rd_req   burst requests to the arbiter
//    wr_ack/rd_ack   pulse: arbiter accepted the burst
//    wr_done/rd_done pulse: burst finished
//    burst_addr      start word address of the requested burst
//    burst_ba        bank (buffer index) of the requested burst
//    frame_done      pulse: a write frame completed
//    wr_bank/rd_bank current write / read buffer
//    frame_valid     at least one complete frame has been written
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no burst outstanding, arbitrating write vs read
// WR_REQ  | wr_req high, waiting for wr_ack
// WR_BUSY | write burst in flight, waiting for wr_done
// RD_REQ  | rd_req high, waiting for rd_ack
// RD_BUSY | read burst in flight, waiting for rd_done

module sdram_frame_sched #(
   parameter int CNT_W       = 10,
   parameter int ADDR_W      = 22,
   parameter int BURST_LEN   = 256,
   parameter int FRAME_WORDS = 307200,
   parameter int WR_THRESH   = 512,
   parameter int RD_THRESH   = 512
) (
   input  logic              sysclk_100M,
   input  logic              rst,
   input  logic [CNT_W-1:0]  w_fifo_count,
   input  logic [CNT_W-1:0]  r_fifo_count,
   input  logic              wr_frame_start,
   output logic              wr_req,
   input  logic              wr_ack,
   input  logic              wr_done,
   output logic              rd_req,
   input  logic              rd_ack,
   input  logic              rd_done,
   output logic [ADDR_W-1:0] burst_addr,
   output logic [1:0]        burst_ba,
   output logic              frame_done,
   output logic [1:0]        wr_bank,
   output logic [1:0]        rd_bank,
   output logic              frame_valid
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;

   localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FRAME_WORDS);
   localparam logic [CNT_W-1:0]  WR_TH   = CNT_W'(WR_THRESH);
   localparam logic [CNT_W-1:0]  RD_TH   = CNT_W'(RD_THRESH);
   localparam logic              LAST_WR = 1'b0;
   localparam logic              LAST_RD = 1'b1;

   state_t            state;
   logic [1:0]        ready_bank;
   logic              fresh;
   logic              last_served;
   logic              start_pend;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;

   logic              wr_pend;
   logic              rd_pend;
   logic              in_wr_phase;
   logic [ADDR_W-1:0] wr_addr_nxt;
   logic [ADDR_W-1:0] rd_addr_nxt;

   assign wr_pend     = (w_fifo_count >= WR_TH);
   assign rd_pend     = frame_valid && (r_fifo_count <= RD_TH);
   assign in_wr_phase = (state == WR_REQ) || (state == WR_BUSY);
   assign wr_addr_nxt = wr_addr + BURST_A;
   assign rd_addr_nxt = rd_addr + BURST_A;

   always_ff @(posedge sysclk_100M or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_req      <= 1'b0;
         rd_req      <= 1'b0;
         burst_addr  <= '0;
         burst_ba    <= 2'd0;
         frame_done  <= 1'b0;
         wr_bank     <= 2'd0;
         rd_bank     <= 2'd2;
         ready_bank  <= 2'd1;
         fresh       <= 1'b0;
         frame_valid <= 1'b0;
         last_served <= LAST_RD;
         start_pend  <= 1'b0;
         wr_addr     <= '0;
         rd_addr     <= '0;
      end else begin
         frame_done <= 1'b0;

         // A restart outside a write burst takes effect at once; during a
         // burst it is held until that burst's data has landed.
         if (wr_frame_start && !in_wr_phase)
            wr_addr <= '0;
         else if (wr_frame_start)
            start_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (wr_pend && (!rd_pend || last_served == LAST_RD)) begin
                  state      <= WR_REQ;
                  wr_req     <= 1'b1;
                  burst_addr <= wr_frame_start ? '0 : wr_addr;
                  burst_ba   <= wr_bank;
               end else if (rd_pend) begin
                  state      <= RD_REQ;
                  rd_req     <= 1'b1;
                  burst_addr <= rd_addr;
                  // Start of a read frame: pick up the newest finished frame
                  // if there is one, otherwise repeat the current buffer.
                  if (rd_addr == '0 && fresh) begin
                     rd_bank    <= ready_bank;
                     ready_bank <= rd_bank;
                     fresh      <= 1'b0;
                     burst_ba   <= ready_bank;
                  end else begin
                     burst_ba   <= rd_bank;
                  end
               end
            end

            WR_REQ: begin
               if (wr_ack) begin
                  wr_req      <= 1'b0;
                  state       <= WR_BUSY;
                  last_served <= LAST_WR;
               end
            end

            WR_BUSY: begin
               if (wr_done) begin
                  state <= IDLE;
                  if (start_pend || wr_frame_start) begin
                     wr_addr    <= '0;
                     start_pend <= 1'b0;
                  end else if (wr_addr_nxt == FRAME_A) begin
                     wr_addr     <= '0;
                     ready_bank  <= wr_bank;
                     // The only index not used by the old writer or the reader.
                     wr_bank     <= 2'd3 - wr_bank - rd_bank;
                     fresh       <= 1'b1;
                     frame_valid <= 1'b1;
                     frame_done  <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr_nxt;
                  end
               end
            end

            RD_REQ: begin
               if (rd_ack) begin
                  rd_req      <= 1'b0;
                  state       <= RD_BUSY;
                  last_served <= LAST_RD;
               end
            end

            RD_BUSY: begin
               if (rd_done) begin
                  state   <= IDLE;
                  rd_addr <= (rd_addr_nxt == FRAME_A) ? '0 : rd_addr_nxt;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_frame_sched.sv
// tb_sdram_frame_sched
//    Directed bench for sdram_frame_sched with a 4-word burst and a
//    16-word frame. Burst-level vectors come from a table; reset and
//    frame-restart corner cases are hand-written sequences.

module tb_sdram_frame_sched;

   logic        sysclk_100M = 1'b0;
   logic        rst;
   logic [9:0]  w_fifo_count;
   logic [9:0]  r_fifo_count;
   logic        wr_frame_start;
   logic        wr_req;
   logic        wr_ack;
   logic        wr_done;
   logic        rd_req;
   logic        rd_ack;
   logic        rd_done;
   logic [21:0] burst_addr;
   logic [1:0]  burst_ba;
   logic        frame_done;
   logic [1:0]  wr_bank;
   logic [1:0]  rd_bank;
   logic        frame_valid;

   int passed = 0;
   int total  = 0;

   sdram_frame_sched #(
      .CNT_W(10), .ADDR_W(22), .BURST_LEN(4), .FRAME_WORDS(16),
      .WR_THRESH(8), .RD_THRESH(8)
   ) dut (
      .sysclk_100M   (sysclk_100M),
      .rst           (rst),
      .w_fifo_count  (w_fifo_count),
      .r_fifo_count  (r_fifo_count),
      .wr_frame_start(wr_frame_start),
      .wr_req        (wr_req),
      .wr_ack        (wr_ack),
      .wr_done       (wr_done),
      .rd_req        (rd_req),
      .rd_ack        (rd_ack),
      .rd_done       (rd_done),
      .burst_addr    (burst_addr),
      .burst_ba      (burst_ba),
      .frame_done    (frame_done),
      .wr_bank       (wr_bank),
      .rd_bank       (rd_bank),
      .frame_valid   (frame_valid)
   );

   always #5 sysclk_100M = ~sysclk_100M;

   typedef struct {
      logic [9:0]  w_cnt;
      logic [9:0]  r_cnt;
      logic        is_wr;
      logic [21:0] addr;
      logic [1:0]  ba;
      logic        fd;
      logic [1:0]  wb;
      logic [1:0]  rb;
   } vec_t;

   vec_t tbl[22];
   vec_t v;

   function automatic vec_t mk(input int w, input int r, input int is_wr,
                               input int addr, input int ba, input int fd,
                               input int wb, input int rb);
      vec_t t;
      t.w_cnt = 10'(w);
      t.r_cnt = 10'(r);
      t.is_wr = 1'(is_wr);
      t.addr  = 22'(addr);
      t.ba    = 2'(ba);
      t.fd    = 1'(fd);
      t.wb    = 2'(wb);
      t.rb    = 2'(rb);
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else
         passed++;
   endtask

   // One full burst: wait for the request, check it, ack, optionally pulse
   // wr_frame_start while busy, finish, then check the bank state.
   task automatic do_burst(input string tag, input vec_t e, input int fs_pulses);
      logic got;
      w_fifo_count = e.w_cnt;
      r_fifo_count = e.r_cnt;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge sysclk_100M);
         if (wr_req || rd_req) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         chk({tag, " request timeout"}, 32'd0, 32'd1);
         return;
      end
      chk({tag, " wr_req"}, 32'(wr_req), 32'(e.is_wr));
      chk({tag, " rd_req"}, 32'(rd_req), 32'(!e.is_wr));
      chk({tag, " burst_addr"}, 32'(burst_addr), 32'(e.addr));
      chk({tag, " burst_ba"}, 32'(burst_ba), 32'(e.ba));
      if (e.is_wr) wr_ack = 1'b1; else rd_ack = 1'b1;
      @(negedge sysclk_100M);
      wr_ack = 1'b0;
      rd_ack = 1'b0;
      chk({tag, " req dropped after ack"}, 32'(wr_req | rd_req), 32'd0);
      for (int p = 0; p < fs_pulses; p++) begin
         wr_frame_start = 1'b1;
         @(negedge sysclk_100M);
         wr_frame_start = 1'b0;
         @(negedge sysclk_100M);
      end
      if (e.is_wr) wr_done = 1'b1; else rd_done = 1'b1;
      @(negedge sysclk_100M);
      wr_done = 1'b0;
      rd_done = 1'b0;
      chk({tag, " frame_done"}, 32'(frame_done), 32'(e.fd));
      chk({tag, " wr_bank"}, 32'(wr_bank), 32'(e.wb));
      chk({tag, " rd_bank"}, 32'(rd_bank), 32'(e.rb));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " wr_req"}, 32'(wr_req), 32'd0);
      chk({tag, " rd_req"}, 32'(rd_req), 32'd0);
      chk({tag, " burst_addr"}, 32'(burst_addr), 32'd0);
      chk({tag, " burst_ba"}, 32'(burst_ba), 32'd0);
      chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, " wr_bank"}, 32'(wr_bank), 32'd0);
      chk({tag, " rd_bank"}, 32'(rd_bank), 32'd2);
      chk({tag, " frame_valid"}, 32'(frame_valid), 32'd0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge sysclk_100M);
         if (wr_req || rd_req) seen = 1'b1;
      end
      chk({tag, " no request"}, 32'(seen), 32'd0);
   endtask

   initial begin
      // First write frame (w at threshold, reads blocked).
      tbl[0]  = mk(8, 100, 1,  0, 0, 0, 0, 2);
      tbl[1]  = mk(9, 100, 1,  4, 0, 0, 0, 2);
      tbl[2]  = mk(8, 100, 1,  8, 0, 0, 0, 2);
      tbl[3]  = mk(8, 100, 1, 12, 0, 1, 1, 2);
      // Reads only: first frame picks up buffer 0, second frame repeats it.
      tbl[4]  = mk(0,   0, 0,  0, 0, 0, 1, 0);
      tbl[5]  = mk(0,   8, 0,  4, 0, 0, 1, 0);
      tbl[6]  = mk(0,   8, 0,  8, 0, 0, 1, 0);
      tbl[7]  = mk(0,   0, 0, 12, 0, 0, 1, 0);
      tbl[8]  = mk(0,   0, 0,  0, 0, 0, 1, 0);
      tbl[9]  = mk(0,   0, 0,  4, 0, 0, 1, 0);
      tbl[10] = mk(0,   0, 0,  8, 0, 0, 1, 0);
      tbl[11] = mk(0,   0, 0, 12, 0, 0, 1, 0);
      // Both pending: alternate, write first since the last burst was a read.
      tbl[12] = mk(8,   0, 1,  0, 1, 0, 1, 0);
      tbl[13] = mk(8,   0, 0,  0, 0, 0, 1, 0);
      tbl[14] = mk(8,   0, 1,  4, 1, 0, 1, 0);
      tbl[15] = mk(8,   0, 0,  4, 0, 0, 1, 0);
      tbl[16] = mk(8,   0, 1,  8, 1, 0, 1, 0);
      tbl[17] = mk(8,   0, 0,  8, 0, 0, 1, 0);
      tbl[18] = mk(8,   0, 1, 12, 1, 1, 2, 0);
      tbl[19] = mk(8,   0, 0, 12, 0, 0, 2, 0);
      tbl[20] = mk(8,   0, 1,  0, 2, 0, 2, 0);
      tbl[21] = mk(8,   0, 0,  0, 1, 0, 2, 1);

      rst = 1'b1;
      w_fifo_count = 10'd0;
      r_fifo_count = 10'd100;
      wr_frame_start = 1'b0;
      wr_ack = 1'b0; wr_done = 1'b0;
      rd_ack = 1'b0; rd_done = 1'b0;
      repeat (2) @(negedge sysclk_100M);
      check_reset_vals("reset");
      chk("reset ready_bank", 32'(dut.ready_bank), 32'd1);
      rst = 1'b0;

      for (int i = 0; i < 22; i++) begin
         do_burst($sformatf("v%0d", i), tbl[i], 0);
         if (i == 3) begin
            chk("frame1 frame_valid", 32'(frame_valid), 32'd1);
            // One below write threshold, one above read threshold.
            w_fifo_count = 10'd7;
            r_fifo_count = 10'd9;
            expect_quiet("below thresholds", 5);
         end
         if (i == 4)
            chk("first read ready_bank", 32'(dut.ready_bank), 32'd2);
      end

      // Reset in the middle of a read burst.
      w_fifo_count = 10'd0;
      r_fifo_count = 10'd0;
      begin : rst_mid
         logic got;
         got = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge sysclk_100M);
            if (rd_req) begin
               got = 1'b1;
               break;
            end
         end
         chk("rst seq rd_req seen", 32'(got), 32'd1);
         chk("rst seq burst_addr", 32'(burst_addr), 32'd4);
         chk("rst seq burst_ba", 32'(burst_ba), 32'd1);
         rd_ack = 1'b1;
         @(negedge sysclk_100M);
         rd_ack = 1'b0;
         #2 rst = 1'b1;
         #1 check_reset_vals("async reset");
         @(negedge sysclk_100M);
         rst = 1'b0;
         rd_done = 1'b1;
         @(negedge sysclk_100M);
         rd_done = 1'b0;
         check_reset_vals("stale rd_done");
         expect_quiet("after reset", 5);
      end

      // Frame restart: latched during a write burst, immediate in IDLE.
      w_fifo_count = 10'd7;
      expect_quiet("w below threshold", 4);
      do_burst("fs0", mk(8, 0, 1, 0, 0, 0, 0, 2), 0);
      do_burst("fs1", mk(8, 0, 1, 4, 0, 0, 0, 2), 0);
      do_burst("fs2 restart in busy", mk(8, 0, 1, 8, 0, 0, 0, 2), 2);
      do_burst("fs3", mk(8, 0, 1, 0, 0, 0, 0, 2), 0);
      w_fifo_count = 10'd0;
      @(negedge sysclk_100M);
      wr_frame_start = 1'b1;
      @(negedge sysclk_100M);
      wr_frame_start = 1'b0;
      do_burst("fs4 restart in idle", mk(8, 0, 1, 0, 0, 0, 0, 2), 0);
      do_burst("fs5", mk(8, 0, 1, 4, 0, 0, 0, 2), 0);
      do_burst("fs6", mk(8, 0, 1, 8, 0, 0, 0, 2), 0);
      do_burst("fs7", mk(8, 0, 1, 12, 0, 1, 1, 2), 0);
      chk("fs frame_valid", 32'(frame_valid), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end

endmodule
